// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_rx_if.sv
// Serial input and byte-output bundle of the UART receiver.
interface uart_rx_if;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;

  modport master (input rx, output dout, rx_done, frame_err);
  modport slave  (output rx, input dout, rx_done, frame_err);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == W'(DIV - 1));
      cnt  <= (cnt == W'(DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled, mid-bit sampling with start-glitch reject.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD);

  logic       rx_meta, rx_s;
  logic       tick;
  rx_state_e  state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;

  uart_baud_tick #(.DIV(DIV)) u_tick (.clk(clk), .rst_n(rst_n), .tick(tick));

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      bus.dout      <= '0;
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.rx_done   <= 1'b0;
      bus.frame_err <= 1'b0;
      if (tick) begin
        case (state)
          IDLE: if (!rx_s) begin
            state    <= START;
            tick_cnt <= '0;
          end
          START: if (tick_cnt == 4'd7) begin
            state    <= rx_s ? IDLE : DATA;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          DATA: if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
            tick_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
            else bit_cnt <= bit_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          STOP: if (tick_cnt == 4'(OVERSAMPLE - 1)) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (rx_s) begin
              bus.dout    <= shreg;
              bus.rx_done <= 1'b1;
            end else begin
              bus.frame_err <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, corner sequences, random frames.
module tb_uart_rx;
  import uart_pkg::*;

  // 115200 baud with a slow clock keeps each bit at 64 clocks (DIV = 4).
  localparam int CLK_FREQ = 7_372_800;
  localparam int BAUD     = 115_200;
  localparam int BIT      = CLK_FREQ / BAUD;
  localparam int LAT_NOM  = (BIT * 19) / 2 + 2;
  localparam int LAT_TOL  = BIT / 16 + 1;

  logic clk = 1'b0;
  logic rst_n;
  uart_rx_if bus ();

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int done_cnt = 0, err_cnt = 0, overlap_cnt = 0;
  int fall_cyc = 0, last_lat = 0;
  logic [7:0] done_dout = '0;

  always @(negedge clk) begin
    if (bus.rx_done) begin
      done_cnt++;
      done_dout = bus.dout;
      last_lat  = cyc - fall_cyc;
    end
    if (bus.frame_err) err_cnt++;
    if (bus.rx_done && bus.frame_err) overlap_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_lat(input string name);
    checks++;
    if (last_lat < LAT_NOM - LAT_TOL || last_lat > LAT_NOM + LAT_TOL) begin
      errors++;
      $display("FAIL %s: got %0d clk, expected %0d +/- %0d", name, last_lat, LAT_NOM, LAT_TOL);
    end
  endtask

  task automatic idle_bits(input int n);
    bus.rx = 1'b1;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    fall_cyc = cyc;
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      bus.rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    bus.rx = stop;
    repeat (BIT) @(negedge clk);
    bus.rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_done;
    int         exp_err;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[7];
  logic [7:0] model_dout;
  int d0, e0;

  initial begin
    vecs[0] = '{8'h8A, 1'b1, 1, 1, 0, 8'h8A};
    vecs[1] = '{8'h55, 1'b1, 0, 1, 0, 8'h55};
    vecs[2] = '{8'hA3, 1'b1, 1, 1, 0, 8'hA3};
    vecs[3] = '{8'h3C, 1'b0, 2, 0, 1, 8'hA3};
    vecs[4] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[5] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
    vecs[6] = '{8'h81, 1'b0, 1, 0, 1, 8'hFF};

    bus.rx = 1'b1;
    rst_n  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_dout", bus.dout, 8'h00);
    check("rst_done", bus.rx_done, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    rst_n = 1'b1;
    idle_bits(2);

    foreach (vecs[i]) begin
      d0 = done_cnt; e0 = err_cnt;
      send(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_done", i), done_cnt - d0, vecs[i].exp_done);
      check($sformatf("vec%0d_ferr", i), err_cnt - e0, vecs[i].exp_err);
      check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      if (vecs[i].exp_done != 0) begin
        check($sformatf("vec%0d_pulse_dout", i), done_dout, vecs[i].exp_dout);
        check_lat($sformatf("vec%0d_latency", i));
      end
      idle_bits(vecs[i].gap);
    end

    // Short low glitch must be rejected at the mid-start-bit sample.
    d0 = done_cnt; e0 = err_cnt;
    bus.rx = 1'b0;
    repeat (3 * (BIT / 16)) @(negedge clk);
    idle_bits(2);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", err_cnt - e0, 0);
    check("glitch_state", int'(dut.state), int'(IDLE));
    check("glitch_dout", bus.dout, 8'hFF);

    // Reset pulse during data bit 4 (a 1 bit) aborts the frame.
    d0 = done_cnt; e0 = err_cnt;
    fall_cyc = cyc;
    bus.rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.rx = (8'h5A >> i) & 1;
      repeat (BIT) @(negedge clk);
    end
    bus.rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(12);
    check("rstmid_done", done_cnt - d0, 0);
    check("rstmid_ferr", err_cnt - e0, 0);
    check("rstmid_dout", bus.dout, 8'h00);
    send(8'hF0, 1'b1);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_dout", bus.dout, 8'hF0);
    check_lat("after_rst_latency");
    idle_bits(1);

    // Random frames against a byte-level model: good stop updates dout, bad stop does not.
    model_dout = 8'hF0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] b;
      logic       s;
      int         gap;
      b   = 8'($urandom);
      s   = ($urandom_range(0, 3) != 0);
      gap = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      d0 = done_cnt; e0 = err_cnt;
      send(b, s);
      if (s) model_dout = b;
      check($sformatf("rnd%0d_done", n), done_cnt - d0, s ? 1 : 0);
      check($sformatf("rnd%0d_ferr", n), err_cnt - e0, s ? 0 : 1);
      check($sformatf("rnd%0d_dout", n), bus.dout, model_dout);
      idle_bits(gap);
    end

    check("pulse_overlap", overlap_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate in bit/s.
REQ-003 clk  input  1  system clock, rising-edge active; one clock domain only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 rx  input  1  serial line: idle high, 8N1 frame, LSB first; asynchronous to clk.
REQ-006 dout  output  8  last correctly received byte.
REQ-007 rx_done  output  1  one-cycle pulse; dout is valid from this cycle on.
REQ-008 frame_err  output  1  one-cycle pulse; the stop bit sampled 0.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-010 A tick generator SHALL divide clk by DIV = CLK_FREQ/(BAUD*16), integer truncation (54 at defaults).
REQ-011 The tick SHALL be a one-cycle pulse every DIV cycles; the counter SHALL be free-running and wrap from DIV-1 to 0.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP and SHALL reset to IDLE.
REQ-013 IDLE -> START when rx_s = 0 on a tick; the 4-bit tick counter SHALL clear on this transition.
REQ-014 START: on tick count 7 (mid start bit), rx_s = 1 SHALL return the FSM to IDLE (glitch reject); otherwise go to DATA with the counter cleared.
REQ-015 DATA: every 16 ticks, rx_s SHALL shift into bit[7] of an 8-bit shift register (LSB arrives first); after the 8th bit, go to STOP.
REQ-016 A 3-bit bit counter SHALL count received data bits 0..7 and clear on entry to DATA.
REQ-017 STOP: on the 16th tick, rx_s = 1 SHALL load dout from the shift register and pulse rx_done for exactly one clk.
REQ-018 STOP: on the 16th tick, rx_s = 0 SHALL pulse frame_err for exactly one clk and leave dout unchanged.
REQ-019 After either STOP outcome the FSM SHALL return to IDLE; a start bit that follows immediately SHALL be accepted (no idle gap required).
REQ-020 rx_done and frame_err SHALL never be high in the same cycle.
REQ-021 Latency: the rx_done pulse SHALL occur 9.5 bit times +/- 1/16 bit + 2 clk after the start bit's falling edge on rx.
REQ-022 dout SHALL hold its value between rx_done pulses.

Reset
REQ-023 When rst_n = 0 on a rising clk edge, all of the following SHALL clear: FSM (to IDLE), tick, bit and shift counters/registers, dout = 8'h00, rx_done = 0, frame_err = 0. Synchronizer flops SHALL load 1 (line idle).
REQ-024 Reset mid-frame SHALL abort the frame with no rx_done and no frame_err; reception SHALL resume at the next falling edge after rst_n = 1.

Structure
REQ-025 A shared package uart_pkg SHALL hold the FSM state enum, the OVERSAMPLE = 16 constant and the DATA_BITS = 8 constant.
REQ-026 The tick generator SHALL be the sub-module uart_baud_tick (ports clk, rst_n, tick; parameter DIV).
REQ-027 uart_rx SHALL be synthesizable: no latches, and all outputs driven from registers.

Verification
REQ-028 Drive the frame for 8'h8A at 115200 baud -> exactly one rx_done pulse, dout = 8'h8A, frame_err stays 0.
REQ-029 Drive back-to-back frames 8'h55 then 8'hA3 with no idle gap -> two rx_done pulses, dout = 8'h55 then 8'hA3.
REQ-030 Drive a low pulse on rx of 3 ticks (~1.6 us) -> no rx_done, no frame_err, FSM back in IDLE.
REQ-031 Drive the frame for 8'h3C with the stop bit forced to 0 -> one frame_err pulse, no rx_done, dout keeps its previous value.
REQ-032 Assert rst_n = 0 for one cycle during bit 4 of a frame -> dout = 8'h00, no pulses; the next frame, 8'hF0, is received correctly.
REQ-033 Loopback: connect the tx output of the team's UART transmitter top (din = 8'h8A) to rx -> dout = 8'h8A, with rx_done following the transmitter's tx_done.
